// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_pkg : parity codes, receiver states and index-width helper shared   |
// |            by the UART transmitter and receiver.                Rev 1.0  |
// +--------------------------------------------------------------------------+
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_t;

    // Counter width able to index n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_2ff : two-flop synchronizer for asynchronous pins.        Rev 1.0  |
// +--------------------------------------------------------------------------+
module sync_2ff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_receiver : mid-bit sampling UART receiver with valid/ready output   |
// |                 and framing/parity/overrun error pulses.       Rev 1.0  |
// +--------------------------------------------------------------------------+
module uart_receiver
    import uart_pkg::*;
#(
    parameter int BAUD_2_CLOCK_RATIO = 1250,
    parameter int UART_DATA_BITS     = 8,
    parameter int UART_STOP_BITS     = 2,
    parameter int UART_PARITY        = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] dout,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic                      frame_err,
    output logic                      parity_err,
    output logic                      overrun_err,
    output logic                      busy
);

    localparam int CNT_W  = $clog2(BAUD_2_CLOCK_RATIO);
    localparam int BIT_W  = idx_width(UART_DATA_BITS);
    localparam int STOP_W = idx_width(UART_STOP_BITS);

    localparam logic [CNT_W-1:0]  c_HALF_LOAD = CNT_W'(BAUD_2_CLOCK_RATIO / 2 - 1);
    localparam logic [CNT_W-1:0]  c_FULL_LOAD = CNT_W'(BAUD_2_CLOCK_RATIO - 1);
    localparam logic [BIT_W-1:0]  c_LAST_BIT  = BIT_W'(UART_DATA_BITS - 1);
    localparam logic [STOP_W-1:0] c_LAST_STOP = STOP_W'(UART_STOP_BITS - 1);

    logic w_rxs;

    sync_2ff #(
        .WIDTH       (1),
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (w_rxs)
    );

    rx_state_t                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BIT_W-1:0]          bit_idx_q, bit_idx_d;
    logic [STOP_W-1:0]         stop_idx_q, stop_idx_d;
    logic [UART_DATA_BITS-1:0] sr_q, sr_d;
    logic [UART_DATA_BITS-1:0] dout_q, dout_d;
    logic                      prev_q, par_err_q, par_err_d;
    logic                      dout_valid_q, dout_valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      parity_err_q, parity_err_d;
    logic                      overrun_q, overrun_d;
    logic                      w_tick, w_par_exp, w_word_done;

    assign w_tick    = (cnt_q == '0);
    assign w_par_exp = (UART_PARITY == PARITY_ODD) ? ~^sr_q : ^sr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            stop_idx_q   <= '0;
            sr_q         <= '0;
            dout_q       <= '0;
            prev_q       <= 1'b1;
            par_err_q    <= 1'b0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            stop_idx_q   <= stop_idx_d;
            sr_q         <= sr_d;
            dout_q       <= dout_d;
            prev_q       <= w_rxs;
            par_err_q    <= par_err_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = w_tick ? c_FULL_LOAD : cnt_q - 1'b1;
        bit_idx_d    = bit_idx_q;
        stop_idx_d   = stop_idx_q;
        sr_d         = sr_q;
        dout_d       = dout_q;
        par_err_d    = par_err_q;
        dout_valid_d = dout_valid_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        overrun_d    = 1'b0;
        w_word_done  = 1'b0;

        case (state_q)
            RX_IDLE: begin
                cnt_d = cnt_q;
                if (prev_q && !w_rxs) begin
                    state_d   = RX_START;
                    cnt_d     = c_HALF_LOAD;
                    par_err_d = 1'b0;
                end
            end
            RX_START: begin
                if (w_tick) begin
                    state_d   = w_rxs ? RX_IDLE : RX_DATA;
                    bit_idx_d = '0;
                end
            end
            RX_DATA: begin
                if (w_tick) begin
                    sr_d      = {w_rxs, sr_q[UART_DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == c_LAST_BIT) begin
                        state_d    = (UART_PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
                        stop_idx_d = '0;
                    end
                end
            end
            RX_PARITY: begin
                if (w_tick) begin
                    par_err_d  = (w_rxs != w_par_exp);
                    state_d    = RX_STOP;
                    stop_idx_d = '0;
                end
            end
            RX_STOP: begin
                if (w_tick) begin
                    if (!w_rxs) begin
                        frame_err_d = 1'b1;
                        state_d     = RX_BREAK;
                    end else if (stop_idx_q == c_LAST_STOP) begin
                        state_d = RX_IDLE;
                        if (par_err_q) parity_err_d = 1'b1;
                        else           w_word_done  = 1'b1;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            RX_BREAK: begin
                if (w_rxs) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase

        // A word may land in the same cycle the previous one is consumed.
        if (dout_valid_q && dout_ready) dout_valid_d = 1'b0;
        if (w_word_done) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = sr_q;
                dout_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign frame_err   = frame_err_q;
    assign parity_err  = parity_err_q;
    assign overrun_err = overrun_q;
    assign busy        = (state_q != RX_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_receiver : directed bench for uart_receiver (16 clk/bit).        |
// |                                                                Rev 1.0  |
// +--------------------------------------------------------------------------+
module tb_uart_receiver;

    localparam int BIT_CLKS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       ready_a = 1'b1, ready_b = 1'b1;
    logic [7:0] dout_a, dout_b;
    logic       valid_a, valid_b;
    logic       fe_a, pe_a, oe_a, busy_a;
    logic       fe_b, pe_b, oe_b, busy_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_receiver #(
        .BAUD_2_CLOCK_RATIO (BIT_CLKS),
        .UART_DATA_BITS     (8),
        .UART_STOP_BITS     (2),
        .UART_PARITY        (0)
    ) u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx_a),
        .dout        (dout_a),
        .dout_valid  (valid_a),
        .dout_ready  (ready_a),
        .frame_err   (fe_a),
        .parity_err  (pe_a),
        .overrun_err (oe_a),
        .busy        (busy_a)
    );

    uart_receiver #(
        .BAUD_2_CLOCK_RATIO (BIT_CLKS),
        .UART_DATA_BITS     (8),
        .UART_STOP_BITS     (2),
        .UART_PARITY        (2)
    ) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx_b),
        .dout        (dout_b),
        .dout_valid  (valid_b),
        .dout_ready  (ready_b),
        .frame_err   (fe_b),
        .parity_err  (pe_b),
        .overrun_err (oe_b),
        .busy        (busy_b)
    );

    // Event monitors: pulse counters and a log of words at each valid rise.
    int         nfe_a = 0, npe_a = 0, noe_a = 0;
    int         nfe_b = 0, npe_b = 0, noe_b = 0;
    logic [7:0] words_a[$];
    logic [7:0] words_b[$];
    logic       pv_a = 1'b0, pv_b = 1'b0;
    logic       seen22 = 1'b0;

    always @(negedge clk) begin
        if (fe_a) nfe_a++;
        if (pe_a) npe_a++;
        if (oe_a) noe_a++;
        if (fe_b) nfe_b++;
        if (pe_b) npe_b++;
        if (oe_b) noe_b++;
        if (valid_a && !pv_a) words_a.push_back(dout_a);
        if (valid_b && !pv_b) words_b.push_back(dout_b);
        if (dout_a == 8'h22) seen22 = 1'b1;
        pv_a = valid_a;
        pv_b = valid_b;
    end

    function automatic logic [7:0] word_a(input int i);
        return (i < words_a.size()) ? words_a[i] : 8'hxx;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic v, input int n);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
        wait_clks(n);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] data, input bit has_par,
                              input logic pbit, input logic stop1, input logic stop2);
        drive(sel, 1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive(sel, data[i], BIT_CLKS);
        if (has_par) drive(sel, pbit, BIT_CLKS);
        drive(sel, stop1, BIT_CLKS);
        drive(sel, stop2, BIT_CLKS);
    endtask

    int base_w;

    initial begin
        // Reset state
        wait_clks(4);
        check("rst_dout", 32'(dout_a), 32'h00);
        check("rst_valid", 32'(valid_a), 32'h0);
        check("rst_busy", 32'(busy_a), 32'h0);
        check("rst_errs", 32'({fe_a, pe_a, oe_a}), 32'h0);
        rst = 1'b0;
        wait_clks(10);

        // Back-to-back frames, consumer always ready
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_clks(20);
        check("b2b_count", 32'(words_a.size()), 32'd2);
        check("b2b_word0", 32'(word_a(0)), 32'hA5);
        check("b2b_word1", 32'(word_a(1)), 32'h3C);
        check("b2b_valid_cleared", 32'(valid_a), 32'h0);
        check("b2b_no_errs", 32'(nfe_a + npe_a + noe_a), 32'd0);

        // Short low glitch is a false start
        rx_a = 1'b0;
        wait_clks(5);
        check("glitch_busy", 32'(busy_a), 32'h1);
        rx_a = 1'b1;
        wait_clks(20);
        check("glitch_idle", 32'(busy_a), 32'h0);
        check("glitch_no_word", 32'(words_a.size()), 32'd2);
        check("glitch_no_errs", 32'(nfe_a + npe_a + noe_a), 32'd0);

        // Second stop bit low, then held-low line, then recovery
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_clks(2);
        check("fe_pulse", 32'(nfe_a), 32'd1);
        check("fe_no_word", 32'(words_a.size()), 32'd2);
        check("fe_valid", 32'(valid_a), 32'h0);
        wait_clks(100);
        check("break_single_fe", 32'(nfe_a), 32'd1);
        check("break_busy", 32'(busy_a), 32'h1);
        rx_a = 1'b1;
        wait_clks(10);
        check("break_exit", 32'(busy_a), 32'h0);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_clks(20);
        check("recover_count", 32'(words_a.size()), 32'd3);
        check("recover_word", 32'(word_a(2)), 32'h81);
        check("recover_dout", 32'(dout_a), 32'h81);

        // Even parity on the second instance
        wait_clks(10);
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_clks(20);
        check("par_ok_count", 32'(words_b.size()), 32'd1);
        check("par_ok_dout", 32'(dout_b), 32'h07);
        check("par_ok_no_pe", 32'(npe_b), 32'd0);
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_clks(20);
        check("par_bad_pe", 32'(npe_b), 32'd1);
        check("par_bad_no_word", 32'(words_b.size()), 32'd1);
        check("par_bad_valid", 32'(valid_b), 32'h0);
        check("par_bad_no_fe", 32'(nfe_b), 32'd0);

        // Overrun: consumer stalls across two frames
        ready_a = 1'b0;
        wait_clks(10);
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_clks(20);
        check("ovr_dout_held", 32'(dout_a), 32'h11);
        check("ovr_valid_held", 32'(valid_a), 32'h1);
        check("ovr_pulse", 32'(noe_a), 32'd1);
        check("ovr_count", 32'(words_a.size()), 32'd4);
        ready_a = 1'b1;
        wait_clks(1);
        check("ovr_drain", 32'(valid_a), 32'h0);
        check("ovr_never_22", 32'(seen22), 32'h0);

        // Reset during data bit 3 aborts the frame silently
        base_w = words_a.size();
        drive(0, 1'b0, BIT_CLKS);
        drive(0, 1'b0, BIT_CLKS);
        drive(0, 1'b0, BIT_CLKS);
        drive(0, 1'b0, BIT_CLKS);
        drive(0, 1'b1, BIT_CLKS / 2);
        rst  = 1'b1;
        rx_a = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(40);
        check("abort_busy", 32'(busy_a), 32'h0);
        check("abort_no_word", 32'(words_a.size()), 32'(base_w));
        check("abort_no_errs", 32'(nfe_a + npe_a + noe_a), 32'd2);
        send_frame(0, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_clks(20);
        check("post_rst_count", 32'(words_a.size()), 32'(base_w + 1));
        check("post_rst_word", 32'(word_a(base_w)), 32'hF0);
        check("post_rst_dout", 32'(dout_a), 32'hF0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
